// File: rtl/mux_n_pkg.sv
// mux_n_pkg
// Shared definitions for the N-channel registered multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the top-level 'mode' input
//   clog2()              : ceiling log2, used to size channel-index fields
package mux_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Written out by hand so that older simulators without $clog2 in
  // constant expressions can still elaborate the design.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_rr_arbiter.sv
// rr_arbiter
// Purely combinational rotating-priority encoder.
// Ports:
//   req       in   N      request vector, one bit per channel
//   last      in   SEL_W  most recently served channel
//   gnt_valid out  1      at least one request is present
//   gnt_idx   out  SEL_W  first requester found scanning from last+1, wrapping
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  int cand;

  // Visit channels in the order last+1, last+2, ... and take the first
  // requester; the channel just served is therefore checked last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// mux_n_rr
// N-channel, W-bit multiplexer with valid/ready on every channel and a
// one-entry output register. Selection is either an external index (fixed
// mode) or fair round-robin arbitration.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   mode       in   1      MODE_FIXED or MODE_RR
//   sel        in   SEL_W  channel used in fixed mode
//   in_data    in   N*W    channel i at [i*W +: W]
//   in_valid   in   N      per-channel valid
//   in_ready   out  N      per-channel ready (combinational, one-hot or zero)
//   out_data   out  W      registered data
//   out_ch     out  SEL_W  channel that produced out_data
//   out_valid  out  1      output register holds a beat
//   out_ready  in   1      consumer takes the beat
module mux_n_rr
  import mux_n_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SEL_W-1:0] last;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fixed_valid;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_data;
  logic             load;
  logic             transfer;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .last      (last),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // The register can accept a new beat whenever it is empty or its current
  // beat is leaving this cycle.
  assign load = !out_valid || out_ready;

  // Comparing against each real channel index means an out-of-range sel
  // (possible when N is not a power of two) simply never matches.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) fixed_valid = 1'b1;
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fixed_valid;
      gnt_idx   = sel;
    end
  end

  // rst_n gates in_ready so nothing is accepted while reset is held.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*W +: W];
      if (rst_n && load && gnt_valid && gnt_idx == SEL_W'(i)) in_ready[i] = 1'b1;
    end
  end

  assign transfer = |(in_valid & in_ready);

  // Output register: data and channel only change on a transfer, so they
  // stay stable under backpressure and after the beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only round-robin transfers advance the pointer, so switching back from
  // fixed mode resumes the rotation where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SEL_W'(N - 1);
    end else if (transfer && mode == MODE_RR) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// tb_mux_n_rr
// Self-checking bench for mux_n_rr: a behavioural reference model compared
// every cycle, directed sequences with literal expectations, a second N=3
// instance for the out-of-range select case, and a randomized run.
module tb_mux_n_rr;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int SEL_W  = 2;
  localparam int N3     = 3;
  localparam int SEL3_W = 2;
  localparam logic [N*W-1:0] RR_DATA  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [N*W-1:0] FIX_DATA = {8'h00, 8'h01, 8'h00, 8'h01};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;

  logic              mode3;
  logic [SEL3_W-1:0] sel3;
  logic [N3*W-1:0]   in_data3;
  logic [N3-1:0]     in_valid3;
  logic [N3-1:0]     in_ready3;
  logic [W-1:0]      out_data3;
  logic [SEL3_W-1:0] out_ch3;
  logic              out_valid3;
  logic              out_ready3;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Reference model state: contents of the output register, the channel
  // served last in round-robin mode, and the channel accepted at the last edge.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_last;
  int           acc;

  logic [N-1:0]   cur_valid;
  logic [N*W-1:0] cur_data;
  logic           r_mode;

  mux_n_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_n_rr #(.N(N3), .W(W)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  always #5 clk = ~clk;

  // Channel the block must accept this cycle, or -1 when none.
  function automatic int model_ready_ch();
    if (rst_n !== 1'b1) return -1;
    if (m_valid && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ready_mask();
    if (model_ready_ch() < 0) return 32'd0;
    return 32'd1 << model_ready_ch();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_last  <= N - 1;
      acc     <= -1;
    end else begin
      acc <= model_ready_ch();
      if (model_ready_ch() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[model_ready_ch()*W +: W];
        m_ch    <= model_ready_ch();
        if (mode) m_last <= model_ready_ch();
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                               input logic [N*W-1:0] d, input logic r);
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_in_ready", 32'(in_ready), ready_mask());
      checkOutput("model_out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("model_out_data", 32'(out_data), 32'(m_data));
      checkOutput("model_out_ch", 32'(out_ch), 32'(m_ch));
    end
  end

  initial begin
    mode = 1'b0; sel = '0; in_data = '0; in_valid = 4'hF; out_ready = 1'b0;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    cur_valid = '0; cur_data = '0; r_mode = 1'b1;

    // Reset values, with requests present to show nothing is accepted.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_ch", 32'(out_ch), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid3", 32'(out_valid3), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // Fixed-select truth table: channel bytes 01,00,01,00.
    for (int s = 0; s < N; s++) begin
      applyStimulus(1'b0, SEL_W'(s), 4'hF, FIX_DATA, 1'b1);
      checkOutput("fixed_out_data", 32'(out_data), (s % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("fixed_out_ch", 32'(out_ch), 32'(s));
    end

    // Round-robin fairness from reset: 0,1,2,3,0,1.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, '0, 4'hF, RR_DATA, 1'b1);
      checkOutput("rr_out_ch", 32'(out_ch), 32'(k % 4));
      checkOutput("rr_out_data", 32'(out_data), 32'(8'hA0 + k % 4));
    end

    // Backpressure: channel 1 beat held for three cycles, then 2 and 3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, '0, 4'hF, RR_DATA, 1'b0);
      checkOutput("bp_out_ch", 32'(out_ch), 32'd1);
      checkOutput("bp_out_data", 32'(out_data), 32'hA1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b1, '0, 4'hF, RR_DATA, 1'b1);
    checkOutput("bp_release_ch", 32'(out_ch), 32'd2);
    applyStimulus(1'b1, '0, 4'hF, RR_DATA, 1'b1);
    checkOutput("bp_next_ch", 32'(out_ch), 32'd3);

    // Sparse round-robin: only channels 1 and 3 request.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, '0, 4'b1010, RR_DATA, 1'b1);
      checkOutput("sparse_out_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
      checkOutput("sparse_idle_ready", 32'(in_ready & 4'b0101), 32'd0);
    end

    // Reset while a beat is held clears the output without a clock edge.
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_data", 32'(out_data), 32'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, '0, 4'hF, RR_DATA, 1'b1);
    checkOutput("post_reset_first_ch", 32'(out_ch), 32'd0);

    // Three-channel instance: select 3 names no channel.
    in_valid = 4'h0;
    in_data3 = {8'hC2, 8'hC1, 8'hC0}; in_valid3 = 3'b111; sel3 = 2'd2; mode3 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("n3_out_valid", 32'(out_valid3), 32'd1);
    checkOutput("n3_out_ch", 32'(out_ch3), 32'd2);
    checkOutput("n3_out_data", 32'(out_data3), 32'hC2);
    sel3 = 2'd3;
    #1;
    checkOutput("n3_oor_in_ready", 32'(in_ready3), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("n3_oor_drained", 32'(out_valid3), 32'd0);
    checkOutput("n3_oor_data_held", 32'(out_data3), 32'hC2);
    in_valid3 = '0;

    // Randomized run: producers hold each beat until accepted, mode flips
    // occasionally, consumer stalls about a quarter of the time.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_valid[i] || acc == i) begin
          cur_valid[i] = ($urandom_range(0, 2) != 0);
          cur_data[i*W +: W] = W'($urandom);
        end
      end
      if ($urandom_range(0, 31) == 0) r_mode = ~r_mode;
      applyStimulus(r_mode, SEL_W'($urandom_range(0, N - 1)), cur_valid, cur_data,
                    ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_rr.md
Name: mux_n_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the fixed 4:1 single-bit combinational mux.
- Adds a valid/ready handshake on every input channel and on the output.
- Adds a one-entry output register, and two selection modes: fixed (external select) and round-robin (fair arbitration).
- Sits between multiple producers and a single consumer; used as a generic channel merger in the sample designs.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel (W >= 1).
- SEL_W, $clog2(N), select/channel-index width (localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  N*W  packed channel data; channel i at bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- out_data  output  W  registered output data.
- out_ch  output  SEL_W  source channel of out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer last=N-1, so channel 0 has highest priority after reset.
  - Mid-operation reset drops any held beat; no input is accepted while rst_n=0 (in_ready=0).
- Load condition: load = !out_valid || out_ready. The output register can take a new beat in the same cycle the old one leaves.
- Grant (combinational):
  - Fixed mode: grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
  - RR mode: grant = first i with in_valid[i]=1, scanning cyclically from last+1 to last (wrap N-1 -> 0).
  - No valid input: no grant.
- in_ready[i] = load && granted && grant==i. At most one in_ready bit is high per cycle.
- Transfer on the rising edge when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - RR mode only: last <= g.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_ch hold their values.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - Full throughput: 1 beat/cycle when out_ready stays high.
- Backpressure: out_valid=1 && out_ready=0 forces all in_ready=0; out_data and out_ch stay stable.
- Pointer rules:
  - last changes only on an RR-mode transfer.
  - Fixed-mode transfers leave last untouched.
  - A switch from fixed to RR resumes from the stored last.
- mode and sel are sampled combinationally every cycle. Changing them with a beat held does not disturb the held beat.
- Producers must hold in_data and in_valid until their handshake completes; the block does not check this.

Decomposition:
- Shared package mux_n_pkg:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - function clog2 for SEL_W (Icarus-compatible).
- One sub-module: rr_arbiter
  - Parameters: N, SEL_W.
  - Inputs: req[N], last.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority encoder.
- Top level: fixed-select path, load logic, output register, pointer register.

Test Plan:
- Fixed-mode truth table: N=4, W=1, in_data=4'b0101, all valid, out_ready=1, sel=0,1,2,3 -> out_data 1,0,1,0 one cycle after each sel, out_ch=sel.
- RR fairness: mode=1, all four channels valid continuously with data 8'hA0..8'hA3, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles; out_data tracks the channel.
- Sparse RR: only channels 1 and 3 valid -> out_ch alternates 1,3,1,3; in_ready[0] and in_ready[2] stay 0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_ch frozen, all in_ready=0. On release, the next beat comes from the next RR channel with no beat lost or duplicated.
- Out-of-range select: N=3, mode=0, sel=3 -> no in_ready, out_valid falls to 0 after the held beat drains.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronously). After release, the first RR grant goes to channel 0.
